text_buffer_tx: RTL and testbench

- Reads the 4-row x 32-column character buffer over the RAM read port and transmits it as 8N1 UART, one row per line, each row terminated by CR LF.
- Triggered by a single-cycle dump request, typically a debounced, single-pulsed button.
- Sits beside the receive path: the UART receiver writes the buffer, and this block reads it back out on the TX pin.

---
 rtl/text_buf_pkg.sv | 19 +
 rtl/uart_tx_core.sv | 67 ++++++
 rtl/text_buffer_tx.sv | 104 ++++++++++
 tb/tb_text_buffer_tx.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/text_buf_pkg.sv
// text_buf_pkg: shared state encoding, character constants and the
// printable-byte substitution used by the buffer dump path.
package text_buf_pkg;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_LATCH, S_START, S_DATA, S_STOP, S_NEXT
   } state_t;

   localparam logic [7:0] CHAR_CR    = 8'h0D;
   localparam logic [7:0] CHAR_LF    = 8'h0A;
   localparam logic [7:0] CHAR_SPACE = 8'h20;
   localparam int         BUF_COLS   = 32;
   localparam int         BUF_ROWS   = 4;

   function automatic logic [7:0] printable(input logic [7:0] b);
      return (b < 8'h20 || b > 8'h7E) ? CHAR_SPACE : b;
   endfunction

endpackage

// File: rtl/uart_tx_core.sv
// uart_tx_core: 8N1 serialiser with a valid/ready byte input; tx is a register
// that trails the bit state by one cycle.
module uart_tx_core
   import text_buf_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10417
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data_i,
   input  logic       valid_i,
   output logic       ready_o,
   output logic       frame_end_o,
   output logic       tx_o
);

   localparam int            CW     = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    sh_q, sh_d;
   logic          tx_q, tx_d;
   logic          tick;

   assign tick        = cnt_q == '0;
   assign ready_o     = state_q == S_IDLE;
   assign frame_end_o = state_q == S_STOP && tick;
   assign tx_o        = tx_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = (state_q == S_IDLE || tick) ? RELOAD : cnt_q - 1'b1;
      bit_d   = bit_q;
      sh_d    = sh_q;
      tx_d    = state_q == S_START ? 1'b0 : state_q == S_DATA ? sh_q[0] : 1'b1;
      case (state_q)
         S_IDLE:  if (valid_i) begin state_d = S_START; sh_d = data_i; end
         S_START: if (tick) begin state_d = S_DATA; bit_d = '0; end
         S_DATA:  if (tick) begin
            sh_d  = sh_q >> 1;
            bit_d = bit_q + 1'b1;
            if (bit_q == 3'd7) state_d = S_STOP;
         end
         S_STOP:  if (tick) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= RELOAD;
         bit_q   <= '0;
         sh_q    <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         tx_q    <= tx_d;
      end
   end

endmodule

// File: rtl/text_buffer_tx.sv
// text_buffer_tx: walks the character buffer in display order and streams it
// through uart_tx_core, one CR LF terminated line per row.
module text_buffer_tx
   import text_buf_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10417,
   parameter int COL_START    = 24,
   parameter int NUM_ROWS     = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic [1:0] rd_row,
   output logic [4:0] rd_col,
   input  logic [7:0] rd_data,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam logic [4:0] FIRST_COL = 5'(COL_START);
   localparam logic [4:0] LAST_COL  = 5'((COL_START + BUF_COLS - 1) % BUF_COLS);
   localparam logic [1:0] LAST_ROW  = 2'(NUM_ROWS - 1);

   // ph_q: 0 = buffer char in flight, 1 = CR in flight, 2 = LF in flight
   state_t     state_q, state_d;
   logic [1:0] row_q, row_d;
   logic [4:0] col_q, col_d;
   logic [1:0] ph_q, ph_d;
   logic       done_q, done_d;
   logic       valid, ready, frame_end;
   logic [7:0] byte_out;

   assign rd_row = row_q;
   assign rd_col = col_q;
   assign busy   = state_q != S_IDLE;
   assign done   = done_q;

   // CR/LF are offered straight from NEXT so they skip the fetch latency
   assign valid    = state_q == S_LATCH ||
                     (state_q == S_NEXT && (ph_q == 2'd1 || (ph_q == 2'd0 && col_q == LAST_COL)));
   assign byte_out = state_q == S_LATCH ? printable(rd_data) : (ph_q == 2'd0 ? CHAR_CR : CHAR_LF);

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      ph_d    = ph_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE:  if (start) begin
            state_d = S_FETCH;
            row_d   = '0;
            col_d   = FIRST_COL;
            ph_d    = '0;
         end
         S_FETCH: state_d = S_LATCH;
         S_LATCH: if (ready) state_d = S_START;
         S_START: if (frame_end) state_d = S_NEXT;
         S_NEXT:  if (valid) begin
            if (ready) begin state_d = S_START; ph_d = ph_q + 2'd1; end
         end else if (ph_q == 2'd0) begin
            col_d   = col_q + 5'd1;
            state_d = S_FETCH;
         end else if (row_q == LAST_ROW) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
         end else begin
            row_d   = row_q + 2'd1;
            col_d   = FIRST_COL;
            ph_d    = '0;
            state_d = S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         row_q   <= '0;
         col_q   <= FIRST_COL;
         ph_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         ph_q    <= ph_d;
         done_q  <= done_d;
      end
   end

   uart_tx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
      .clk         (clk),
      .rst_n       (reset),
      .data_i      (byte_out),
      .valid_i     (valid),
      .ready_o     (ready),
      .frame_end_o (frame_end),
      .tx_o        (tx)
   );

endmodule

// File: tb/tb_text_buffer_tx.sv
// tb_text_buffer_tx: drives dumps of a modelled buffer and checks the decoded
// UART stream, read addresses and frame timing against a byte-level model.
module tb_text_buffer_tx;

   logic       clk = 1'b0, reset = 1'b0, start = 1'b0;
   logic [1:0] rd_row;
   logic [4:0] rd_col;
   logic [7:0] rd_data;
   logic       tx, busy, done;
   logic [7:0] mem [4][32];
   int         checks = 0, errors = 0, done_cnt = 0;
   logic       busy_at_done = 1'b1;
   logic [7:0] got_q[$];
   time        fall_q[$];
   logic [6:0] addr_q[$];
   logic       frm_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) rd_data <= mem[rd_row][rd_col];

   text_buffer_tx #(.CLKS_PER_BIT(4), .COL_START(24), .NUM_ROWS(4)) u_dut (
      .clk(clk), .reset(reset), .start(start), .rd_row(rd_row), .rd_col(rd_col),
      .rd_data(rd_data), .tx(tx), .busy(busy), .done(done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // UART receiver: 4 clk per bit, sampled near bit centres on negedges
   initial begin
      logic [7:0] b;
      logic       ok;
      time        tf;
      logic [6:0] a;
      forever begin
         @(negedge clk);
         if (tx === 1'b0) begin
            tf = $time;
            a  = {rd_row, rd_col};
            repeat (2) @(negedge clk);
            ok = tx === 1'b0;
            for (int k = 0; k < 8; k++) begin
               repeat (4) @(negedge clk);
               b[k] = tx;
            end
            repeat (4) @(negedge clk);
            ok = ok && tx === 1'b1;
            got_q.push_back(b);
            fall_q.push_back(tf);
            addr_q.push_back(a);
            frm_q.push_back(ok);
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (done === 1'b1) begin
         done_cnt++;
         busy_at_done = busy;
      end
   end

   task automatic run_dump(input bit extra);
      logic [7:0] exp_q[$];
      logic [6:0] expa_q[$];
      int         gap_q[$];
      int         b0, d0, c;
      logic [7:0] v;
      time        ts, t;
      bit         seen;
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < 32; k++) begin
            c = (24 + k) % 32;
            v = mem[r][c];
            exp_q.push_back((v < 8'h20 || v > 8'h7E) ? 8'h20 : v);
            expa_q.push_back({r[1:0], c[4:0]});
            gap_q.push_back(3);
         end
         exp_q.push_back(8'h0D); expa_q.push_back({r[1:0], 5'd23}); gap_q.push_back(1);
         exp_q.push_back(8'h0A); expa_q.push_back({r[1:0], 5'd23}); gap_q.push_back(1);
      end
      b0 = got_q.size();
      d0 = done_cnt;
      @(negedge clk);
      start = 1'b1;
      ts = $time;
      seen = 1'b0;
      for (int i = 0; i < 7000 && !seen; i++) begin
         @(negedge clk);
         start = extra && i == 200;
         seen  = done_cnt != d0;
      end
      start = 1'b0;
      check("done_seen", 32'(seen), 1);
      check("busy_at_done", 32'(busy_at_done), 0);
      repeat (60) @(negedge clk);
      check("byte_count", got_q.size() - b0, 136);
      check("done_pulses", done_cnt - d0, 1);
      check("busy_after", 32'(busy), 0);
      check("tx_after", 32'(tx), 1);
      t = ts + 40;
      for (int i = 0; i < 136 && b0 + i < got_q.size(); i++) begin
         check($sformatf("byte%0d", i), 32'(got_q[b0+i]), 32'(exp_q[i]));
         check($sformatf("addr%0d", i), 32'(addr_q[b0+i]), 32'(expa_q[i]));
         check($sformatf("fall%0d", i), 32'(fall_q[b0+i]), 32'(t));
         check($sformatf("frame%0d", i), 32'(frm_q[b0+i]), 1);
         if (i < 135) t = t + 400 + 10 * gap_q[i+1];
      end
   endtask

   task automatic fill(input int mode);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 32; c++)
            mem[r][c] = mode == 0 ? 8'h41 : mode == 1 ? 8'h00 : 8'($urandom_range(0, 255));
   endtask

   initial begin
      int bad;
      fill(0);
      repeat (5) @(negedge clk);
      check("rst_tx", 32'(tx), 1);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_row", 32'(rd_row), 0);
      check("rst_col", 32'(rd_col), 24);
      reset = 1'b1;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || rd_col !== 5'd24) bad++;
      end
      check("idle_stable", bad, 0);
      check("idle_no_bytes", got_q.size(), 0);

      run_dump(1'b0);

      fill(1);
      mem[0][24] = 8'h48;
      mem[0][25] = 8'h69;
      run_dump(1'b0);

      fill(2);
      run_dump(1'b1);

      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (189) @(negedge clk);
      check("busy_before_reset", 32'(busy), 1);
      reset = 1'b0;
      #1;
      check("abort_tx", 32'(tx), 1);
      check("abort_busy", 32'(busy), 0);
      check("abort_row", 32'(rd_row), 0);
      check("abort_col", 32'(rd_col), 24);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (60) @(negedge clk);
      fill(2);
      run_dump(1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
